safe_lock_controller: RTL and testbench

Clocked sequencer for the keypad safe. It consumes decoded key events (BCD digits, `*`, `#`) and owns the password register and the digit entry buffer. It runs the lock/unlock/password-change state machine and enforces a lockout after repeated wrong entries. It sits between the keypad encoder and the safe's LED/state outputs, replacing the unclocked star/sharp edge logic with a single synchronous control point.

---
 rtl/safe_lock_controller.sv | 132 +++++++++++++
 tb/tb_safe_lock_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/safe_lock_controller.sv
// safe_lock_controller: keypad safe sequencer (entry, check, open, password change).
// Optional lockout after repeated wrong entries is enabled by defining SAFE_LOCKOUT_EN.
module safe_lock_controller #(
    parameter int          PW_LEN      = 6,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 1000,
    parameter logic [23:0] DEFAULT_PW  = 24'h123456
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       reset_password,
    input  logic       initialize,
    output logic [5:0] password_led,
    output logic [2:0] state,
    output logic       unlock,
    output logic       alarm
);
    typedef enum logic [2:0] {OFF = 3'd0, ENTER = 3'd1, CHECK = 3'd2, OPEN = 3'd3, NEWPW = 3'd4, LOCKOUT = 3'd5} st_t;
    localparam logic [23:0] MASK = 24'hffffff >> (24 - 4 * PW_LEN);
    st_t         cur, nxt;
    logic [23:0] entry, entry_n, pw, pw_n;
    logic [2:0]  cnt, cnt_n;
    logic        digit, star, sharp, full, match, clear_all;
    assign digit = key_valid && key_code < 4'd10;
    assign star  = key_valid && key_code == 4'd10;
    assign sharp = key_valid && key_code == 4'd11;
    assign full  = cnt == 3'(PW_LEN);
    assign match = full && ((entry ^ pw) & MASK) == 24'd0;
`ifdef SAFE_LOCKOUT_EN
    localparam int TW = $clog2(LOCK_CYCLES);
    logic [2:0]    fails, fails_n;
    logic [TW-1:0] timer, timer_n;
    // initialize must not cut a lockout short
    assign clear_all = reset || (initialize && cur != LOCKOUT);
    assign alarm     = cur == LOCKOUT;
`else
    assign clear_all = reset || initialize;
    assign alarm     = 1'b0;
`endif
    assign state        = cur;
    assign unlock       = cur == OPEN;
    assign password_led = (cur == ENTER || cur == NEWPW) ? 6'((7'd1 << cnt) - 7'd1) : (cur == OPEN ? 6'h3f : 6'h00);
    always_ff @(posedge clk) begin
        if (clear_all) begin
            cur   <= OFF;
            entry <= '0;
            cnt   <= '0;
            pw    <= DEFAULT_PW;
`ifdef SAFE_LOCKOUT_EN
            fails <= '0;
            timer <= '0;
`endif
        end else begin
            cur   <= nxt;
            entry <= entry_n;
            cnt   <= cnt_n;
            pw    <= pw_n;
`ifdef SAFE_LOCKOUT_EN
            fails <= fails_n;
            timer <= timer_n;
`endif
        end
    end
    always_comb begin
        nxt     = cur;
        entry_n = entry;
        cnt_n   = cnt;
        pw_n    = pw;
`ifdef SAFE_LOCKOUT_EN
        fails_n = fails;
        timer_n = timer;
`endif
        case (cur)
            OFF: if (sharp) begin
                nxt     = ENTER;
                entry_n = '0;
                cnt_n   = '0;
            end
            ENTER: if (sharp) nxt = CHECK;
            else if (star) begin
                entry_n = '0;
                cnt_n   = '0;
            end else if (digit && !full) begin
                entry_n = {entry[19:0], key_code};
                cnt_n   = cnt + 3'd1;
            end
            CHECK: if (match) begin
                nxt = OPEN;
`ifdef SAFE_LOCKOUT_EN
                fails_n = '0;
`endif
            end else begin
                nxt     = ENTER;
                entry_n = '0;
                cnt_n   = '0;
`ifdef SAFE_LOCKOUT_EN
                fails_n = fails + 3'd1;
                if (fails_n == 3'(MAX_TRIES)) begin
                    nxt     = LOCKOUT;
                    timer_n = TW'(LOCK_CYCLES - 1);
                end
`endif
            end
            OPEN: if (sharp) nxt = OFF;
            else if (reset_password) begin
                nxt     = NEWPW;
                entry_n = '0;
                cnt_n   = '0;
            end
            NEWPW: if (sharp && full) begin
                pw_n = entry;
                nxt  = OPEN;
            end else if (sharp) begin
                entry_n = '0;
                cnt_n   = '0;
            end else if (star) nxt = OPEN;
            else if (digit && !full) begin
                entry_n = {entry[19:0], key_code};
                cnt_n   = cnt + 3'd1;
            end
`ifdef SAFE_LOCKOUT_EN
            LOCKOUT: if (timer == '0) begin
                nxt     = OFF;
                fails_n = '0;
            end else timer_n = timer - 1'b1;
`endif
            default: nxt = OFF;
        endcase
    end
endmodule

// File: tb/tb_safe_lock_controller.sv
// tb_safe_lock_controller: directed and random keypad traffic checked every cycle
// against a digit-queue model of the safe; literal checks pin the model.
module tb_safe_lock_controller;
    localparam int          PW_LEN = 6;
    localparam int          MAX_TRIES = 3;
    localparam int          LOCK_CYCLES = 16;
    localparam logic [23:0] DEFAULT_PW = 24'h123456;
`ifdef SAFE_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    logic       clk = 0, reset = 1, key_valid = 0, reset_password = 0, initialize = 0;
    logic [3:0] key_code = 0;
    logic [5:0] password_led;
    logic [2:0] state;
    logic       unlock, alarm;
    int         total = 0, bad = 0;
    bit         checking = 0;

    safe_lock_controller #(.PW_LEN(PW_LEN), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_PW(DEFAULT_PW)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .reset_password(reset_password), .initialize(initialize),
        .password_led(password_led), .state(state), .unlock(unlock), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // model: state by its numeric code, entry as a digit queue, lockout as a start cycle
    int m_state = 0, m_fails = 0, cyc = 0, lock_start = 0;
    int ent[$];
    int m_pw[PW_LEN];

    function automatic bit pw_match();
        if (ent.size() != PW_LEN) return 0;
        for (int i = 0; i < PW_LEN; i++) if (ent[i] != m_pw[i]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        bit kd, ks, kh;
        cyc++;
        kd = key_valid && key_code < 10;
        ks = key_valid && key_code == 10;
        kh = key_valid && key_code == 11;
        if (reset || (initialize && !(LOCK_EN && m_state == 5))) begin
            m_state = 0;
            m_fails = 0;
            ent.delete();
            for (int i = 0; i < PW_LEN; i++) m_pw[i] = int'((DEFAULT_PW >> (4 * (PW_LEN - 1 - i))) & 24'hf);
        end else if (m_state == 0) begin
            if (kh) begin m_state = 1; ent.delete(); end
        end else if (m_state == 1 || m_state == 4) begin
            if (kh && m_state == 1) m_state = 2;
            else if (kh) begin
                if (ent.size() == PW_LEN) begin
                    for (int i = 0; i < PW_LEN; i++) m_pw[i] = ent[i];
                    m_state = 3;
                end else ent.delete();
            end else if (ks && m_state == 1) ent.delete();
            else if (ks) m_state = 3;
            else if (kd && ent.size() < PW_LEN) ent.push_back(int'(key_code));
        end else if (m_state == 2) begin
            if (pw_match()) begin m_state = 3; m_fails = 0; end
            else begin
                m_fails++;
                if (LOCK_EN && m_fails == MAX_TRIES) begin m_state = 5; lock_start = cyc; end
                else begin m_state = 1; ent.delete(); end
            end
        end else if (m_state == 3) begin
            if (kh) m_state = 0;
            else if (reset_password) begin m_state = 4; ent.delete(); end
        end else if (m_state == 5) begin
            if (cyc - lock_start == LOCK_CYCLES) begin m_state = 0; m_fails = 0; end
        end else m_state = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (checking) begin
        chk("state", 32'(state), 32'(m_state));
        chk("led", 32'(password_led), (m_state == 1 || m_state == 4) ? (32'd1 << ent.size()) - 1 : (m_state == 3 ? 32'd63 : 32'd0));
        chk("unlock", 32'(unlock), 32'(m_state == 3));
        chk("alarm", 32'(alarm), 32'(m_state == 5));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1;
        key_code = c;
        @(negedge clk);
        key_valid = 0;
    endtask

    task automatic keys(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) key(4'((v >> (4 * i)) & 24'hf));
    endtask

    task automatic type_pw();
        for (int i = 0; i < PW_LEN; i++) key(4'(m_pw[i]));
        key(4'd11);
        idle(1);
    endtask

    initial begin
        int acnt;
        idle(2);
        checking = 1;
        chk("reset_state", 32'(state), 0);
        chk("reset_led", 32'(password_led), 0);
        chk("reset_unlock", 32'(unlock), 0);
        chk("reset_alarm", 32'(alarm), 0);
        reset = 0;
        key(4'd11);
        chk("off_to_enter", 32'(state), 1);
        keys(24'h123456, 6);
        chk("led_full", 32'(password_led), 63);
        key(4'd11);
        chk("to_check", 32'(state), 2);
        idle(1);
        chk("open", 32'(state), 3);
        chk("open_unlock", 32'(unlock), 1);
        chk("open_led", 32'(password_led), 63);
        key(4'd11);
        chk("open_to_off", 32'(state), 0);
        key(4'd11);
        key(4'd1); chk("led1", 32'(password_led), 1);
        key(4'd2); chk("led3", 32'(password_led), 3);
        key(4'd9); chk("led7", 32'(password_led), 7);
        key(4'd10); chk("star_clear", 32'(password_led), 0);
        keys(24'h123456, 6);
        key(4'd11); idle(1);
        chk("open_after_star", 32'(state), 3);
        key(4'd11); key(4'd11);
        keys(24'h123456, 6); key(4'd7);
        chk("led_saturate", 32'(password_led), 63);
        key(4'd11); idle(1);
        chk("open_7th_dropped", 32'(state), 3);
        reset_password = 1; idle(1); reset_password = 0;
        chk("newpw", 32'(state), 4);
        keys(24'h987654, 6); key(4'd11);
        chk("newpw_written", 32'(state), 3);
        key(4'd11);
        key(4'd11); keys(24'h123456, 6); key(4'd11); idle(1);
        chk("old_pw_rejected", 32'(state), 1);
        keys(24'h987654, 6); key(4'd11); idle(1);
        chk("new_pw_accepted", 32'(state), 3);
        initialize = 1; idle(1); initialize = 0;
        chk("init_off", 32'(state), 0);
        key(4'd11); keys(24'h123456, 6); key(4'd11); idle(1);
        chk("init_restores_pw", 32'(state), 3);
        key(4'd11); key(4'd11); key(4'd1); key(4'd2); key(4'd11);
        chk("check_before_reset", 32'(state), 2);
        reset = 1; idle(1); reset = 0;
        chk("reset_in_check", 32'(state), 0);
        chk("reset_in_check_led", 32'(password_led), 0);
        if (LOCK_EN) begin
            key(4'd11);
            for (int t = 0; t < MAX_TRIES; t++) begin
                key(4'd1); key(4'd11);
                if (t < MAX_TRIES - 1) begin idle(1); chk("wrong_retry", 32'(state), 1); end
            end
            acnt = 0;
            for (int i = 0; i < 2 * LOCK_CYCLES + 8; i++) begin
                initialize = i > 0;
                key_valid = 1'($urandom_range(0, 1));
                key_code = 4'($urandom_range(0, 15));
                @(negedge clk);
                if (alarm) acnt++;
            end
            initialize = 0; key_valid = 0;
            chk("alarm_cycles", 32'(acnt), LOCK_CYCLES);
            chk("after_lockout", 32'(state), 0);
        end
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin key(4'd11); type_pw(); end
            else if (r == 2) begin reset_password = 1; idle(1); reset_password = 0; end
            else begin
                key_valid = 1'($urandom_range(0, 1));
                key_code = ($urandom_range(0, 3) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
                initialize = $urandom_range(0, 99) == 0;
                reset = $urandom_range(0, 199) == 0;
                @(negedge clk);
                key_valid = 0; initialize = 0; reset = 0;
            end
        end
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
